// File: rtl/sram_dp_be_if.sv
// Purpose: request/response bundle for the simple-dual-port byte-enable SRAM.
// Latency: none, this is wiring only.
// Backpressure: none; the requester must hold off while BUSY is high.
interface sram_dp_be_if #(
  parameter int BW = 32,
  parameter int AW = 10
);
  logic            RCSN;
  logic [AW-1:0]   RA;
  logic            WEN;
  logic [AW-1:0]   WA;
  logic [BW/8-1:0] BE;
  logic [BW-1:0]   DI;
  logic [BW-1:0]   DOUT;
  logic            RVALID;
  logic            BUSY;

  modport master (
    output RCSN, RA, WEN, WA, BE, DI,
    input  DOUT, RVALID, BUSY
  );

  modport slave (
    input  RCSN, RA, WEN, WA, BE, DI,
    output DOUT, RVALID, BUSY
  );
endinterface

// File: rtl/sram_dp_be.sv
// Purpose: simple-dual-port SRAM with byte-enable writes and a post-reset clear engine.
// Latency: read data and RVALID appear RLAT (1 or 2) edges after the request edge.
// Backpressure: none per request; BUSY high while clearing, requests then dropped.
// Macro SRAM_BYPASS_EN: same-cycle read/write to one address returns the merged word.
module sram_dp_be #(
  parameter int            BW       = 32,
  parameter int            AW       = 10,
  parameter int            ENTRY    = 1024,
  parameter int            RLAT     = 1,
  parameter logic [BW-1:0] INIT_VAL = '0
) (
  input logic         CLK,
  input logic         RST,
  sram_dp_be_if.slave bus
);
  localparam int            NB       = BW / 8;
  localparam int            IW       = (ENTRY > 1) ? $clog2(ENTRY) : 1;
  localparam logic [AW:0]   ENTRY_W  = (AW+1)'(ENTRY);
  localparam logic [AW-1:0] LAST_CNT = AW'(ENTRY - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic            busy;
  logic            clr_we;
  logic            ready;

  logic [BW-1:0]   ram [0:ENTRY-1];
  logic            ra_in_range;
  logic            wa_in_range;
  logic [IW-1:0]   ra_idx;
  logic [IW-1:0]   wa_idx;
  logic [IW-1:0]   cnt_idx;
  logic            rd_ok;
  logic            wr_ok;
  logic [BW-1:0]   rd_word;

  logic [BW-1:0]   dout_q;
  logic            rvld_q;

  // State register: reset wins from any state
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_RESET;
    else     state <= state_nxt;
  end

  // Next state: leave RESET on first low-RST edge, leave CLEAR after last entry
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_CLEAR;
      ST_CLEAR: if (cnt == LAST_CNT) state_nxt = ST_READY;
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // State decode: busy until READY, clear writes only in CLEAR
  always_comb begin
    busy   = 1'b1;
    clr_we = 1'b0;
    ready  = 1'b0;
    case (state)
      ST_CLEAR: clr_we = 1'b1;
      ST_READY: begin
        busy  = 1'b0;
        ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Clear pointer: held at 0 outside CLEAR so every clear restarts from entry 0
  always_ff @(posedge CLK) begin
    if (RST || !clr_we) cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

  assign ra_in_range = ({1'b0, bus.RA} < ENTRY_W);
  assign wa_in_range = ({1'b0, bus.WA} < ENTRY_W);
  assign ra_idx      = bus.RA[IW-1:0];
  assign wa_idx      = bus.WA[IW-1:0];
  assign cnt_idx     = cnt[IW-1:0];
  assign rd_ok       = ready && !bus.RCSN;
  assign wr_ok       = ready && !bus.WEN && wa_in_range;

  // Storage: clear engine has priority, otherwise byte-masked user write
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      ram[cnt_idx] <= INIT_VAL;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.BE[i]) ram[wa_idx][8*i +: 8] <= bus.DI[8*i +: 8];
      end
    end
  end

  // Read word: out-of-range reads yield 0; collision handling per build
  always_comb begin
    rd_word = '0;
    if (ra_in_range) begin
      rd_word = ram[ra_idx];
`ifdef SRAM_BYPASS_EN
      if (wr_ok && (bus.WA == bus.RA)) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.BE[i]) rd_word[8*i +: 8] = bus.DI[8*i +: 8];
        end
      end
`else
      // Array read sees pre-edge contents, so a collision returns old data.
`endif
    end
  end

  generate
    if (RLAT == 1) begin : g_lat1
      // Single output register loaded on the request edge; DOUT holds otherwise
      always_ff @(posedge CLK) begin
        if (RST) begin
          dout_q <= '0;
          rvld_q <= 1'b0;
        end else begin
          rvld_q <= rd_ok;
          if (rd_ok) dout_q <= rd_word;
        end
      end
    end else if (RLAT == 2) begin : g_lat2
      logic [BW-1:0] d1_q;
      logic          v1_q;
      // Two-stage pipeline: sample stage then output stage, both flushed by reset
      always_ff @(posedge CLK) begin
        if (RST) begin
          d1_q   <= '0;
          v1_q   <= 1'b0;
          dout_q <= '0;
          rvld_q <= 1'b0;
        end else begin
          v1_q   <= rd_ok;
          if (rd_ok) d1_q <= rd_word;
          rvld_q <= v1_q;
          if (v1_q) dout_q <= d1_q;
        end
      end
    end else begin : g_bad_rlat
      $error("sram_dp_be: RLAT must be 1 or 2");
    end
  endgenerate

  assign bus.DOUT   = dout_q;
  assign bus.RVALID = rvld_q;
  assign bus.BUSY   = busy;
endmodule

// File: tb/tb_sram_dp_be.sv
// Purpose: directed self-checking bench for sram_dp_be, RLAT=1 and RLAT=2 side by side.
// Latency: both instances get identical stimulus; outputs sampled 1ns after each edge.
// Backpressure: BUSY waits are bounded by a cycle budget.
module tb_sram_dp_be;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  sram_dp_be_if #(.BW(32), .AW(5)) if1 ();
  sram_dp_be_if #(.BW(32), .AW(5)) if2 ();

  sram_dp_be #(
    .BW(32), .AW(5), .ENTRY(16), .RLAT(1), .INIT_VAL(32'hA5A5A5A5)
  ) u_dut1 (
    .CLK(CLK),
    .RST(RST),
    .bus(if1)
  );

  sram_dp_be #(
    .BW(32), .AW(5), .ENTRY(16), .RLAT(2), .INIT_VAL(32'hA5A5A5A5)
  ) u_dut2 (
    .CLK(CLK),
    .RST(RST),
    .bus(if2)
  );

  task automatic drive(input logic rcsn, input logic [4:0] ra, input logic wen,
                       input logic [4:0] wa, input logic [31:0] di, input logic [3:0] be);
    if1.RCSN = rcsn; if1.RA = ra; if1.WEN = wen; if1.WA = wa; if1.DI = di; if1.BE = be;
    if2.RCSN = rcsn; if2.RA = ra; if2.WEN = wen; if2.WA = wa; if2.DI = di; if2.BE = be;
  endtask

  task automatic idle();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    int n;
    RST = 1'b1;
    idle();
    repeat (3) tick();
    checks++;
    if (if1.DOUT !== 32'h0 || if1.RVALID !== 1'b0 || if1.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_state1 dout=%h rvalid=%b busy=%b expected 0/0/1", if1.DOUT, if1.RVALID, if1.BUSY);
    end
    checks++;
    if (if2.DOUT !== 32'h0 || if2.RVALID !== 1'b0 || if2.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_state2 dout=%h rvalid=%b busy=%b expected 0/0/1", if2.DOUT, if2.RVALID, if2.BUSY);
    end
    RST = 1'b0;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (if1.BUSY === 1'b0) break;
    end
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL clear_edges edges=%0d expected=17", n);
    end
    checks++;
    if (if2.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy2 busy=%b expected=0", if2.BUSY);
    end
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 5'(a), 1'b1, 5'd0, 32'h0, 4'h0);
      tick();
      checks++;
      if (if1.DOUT !== 32'hA5A5A5A5 || if1.RVALID !== 1'b1) begin
        errors++;
        $display("FAIL clear_read addr=%0d dout=%h rvalid=%b expected a5a5a5a5/1", a, if1.DOUT, if1.RVALID);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_byte_write();
    drive(1'b1, 5'd0, 1'b0, 5'd3, 32'h11223344, 4'b1111);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd3, 32'hFFFFFFFF, 4'b0101);
    tick();
    drive(1'b0, 5'd3, 1'b1, 5'd0, 32'h0, 4'h0);
    tick();
    checks++;
    if (if1.DOUT !== 32'h11FF33FF || if1.RVALID !== 1'b1) begin
      errors++;
      $display("FAIL byte_write dout=%h rvalid=%b expected 11ff33ff/1", if1.DOUT, if1.RVALID);
    end
    // BE=0 write is a no-op
    drive(1'b1, 5'd0, 1'b0, 5'd3, 32'h00000000, 4'b0000);
    tick();
    drive(1'b0, 5'd3, 1'b1, 5'd0, 32'h0, 4'h0);
    tick();
    checks++;
    if (if1.DOUT !== 32'h11FF33FF) begin
      errors++;
      $display("FAIL be_zero_noop dout=%h expected=11ff33ff", if1.DOUT);
    end
    // Out-of-range write dropped, out-of-range read returns 0 with RVALID
    drive(1'b1, 5'd0, 1'b0, 5'd20, 32'h12345678, 4'b1111);
    tick();
    drive(1'b0, 5'd20, 1'b1, 5'd0, 32'h0, 4'h0);
    tick();
    checks++;
    if (if1.DOUT !== 32'h0 || if1.RVALID !== 1'b1) begin
      errors++;
      $display("FAIL oor_read dout=%h rvalid=%b expected 0/1", if1.DOUT, if1.RVALID);
    end
    drive(1'b0, 5'd4, 1'b1, 5'd0, 32'h0, 4'h0);
    tick();
    checks++;
    if (if1.DOUT !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL oor_no_alias dout=%h expected=a5a5a5a5", if1.DOUT);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_dat [8];
    for (int i = 0; i < 8; i++) begin
      exp_dat[i] = 32'h1000_0000 + 32'(i);
      drive(1'b1, 5'd0, 1'b0, 5'(i), exp_dat[i], 4'b1111);
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(1'b0, 5'(c), 1'b1, 5'd0, 32'h0, 4'h0);
      else       idle();
      tick();
      checks++;
      if (if1.RVALID !== (c < 8)) begin
        errors++;
        $display("FAIL lat1_rvalid cycle=%0d rvalid=%b expected=%b", c, if1.RVALID, (c < 8));
      end
      if (c < 8) begin
        checks++;
        if (if1.DOUT !== exp_dat[c]) begin
          errors++;
          $display("FAIL lat1_data cycle=%0d dout=%h expected=%h", c, if1.DOUT, exp_dat[c]);
        end
      end
      checks++;
      if (if2.RVALID !== (c >= 1 && c <= 8)) begin
        errors++;
        $display("FAIL lat2_rvalid cycle=%0d rvalid=%b expected=%b", c, if2.RVALID, (c >= 1 && c <= 8));
      end
      if (c >= 1 && c <= 8) begin
        checks++;
        if (if2.DOUT !== exp_dat[c-1]) begin
          errors++;
          $display("FAIL lat2_data cycle=%0d dout=%h expected=%h", c, if2.DOUT, exp_dat[c-1]);
        end
      end
    end
    checks++;
    if (if1.DOUT !== exp_dat[7] || if2.DOUT !== exp_dat[7]) begin
      errors++;
      $display("FAIL dout_hold dout1=%h dout2=%h expected=%h", if1.DOUT, if2.DOUT, exp_dat[7]);
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_col;
`ifdef SRAM_BYPASS_EN
    exp_col = 32'h0000BEEF;
`else
    exp_col = 32'h00000000;
`endif
    drive(1'b1, 5'd0, 1'b0, 5'd5, 32'h0, 4'b1111);
    tick();
    drive(1'b0, 5'd5, 1'b0, 5'd5, 32'hDEADBEEF, 4'b0011);
    tick();
    checks++;
    if (if1.DOUT !== exp_col || if1.RVALID !== 1'b1) begin
      errors++;
      $display("FAIL collision1 dout=%h rvalid=%b expected %h/1", if1.DOUT, if1.RVALID, exp_col);
    end
    idle();
    tick();
    checks++;
    if (if2.DOUT !== exp_col || if2.RVALID !== 1'b1) begin
      errors++;
      $display("FAIL collision2 dout=%h rvalid=%b expected %h/1", if2.DOUT, if2.RVALID, exp_col);
    end
    drive(1'b0, 5'd5, 1'b1, 5'd0, 32'h0, 4'h0);
    tick();
    checks++;
    if (if1.DOUT !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL collision_after dout=%h expected=0000beef", if1.DOUT);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    // Read in flight when reset hits
    drive(1'b0, 5'd3, 1'b1, 5'd0, 32'h0, 4'h0);
    tick();
    RST = 1'b1;
    tick();
    checks++;
    if (if1.DOUT !== 32'h0 || if1.RVALID !== 1'b0 || if2.DOUT !== 32'h0 ||
        if2.RVALID !== 1'b0 || if1.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_inflight dout1=%h rv1=%b dout2=%h rv2=%b busy=%b expected 0/0/0/0/1",
               if1.DOUT, if1.RVALID, if2.DOUT, if2.RVALID, if1.BUSY);
    end
    // Release with requests held active, then reset again mid-clear
    RST = 1'b0;
    drive(1'b0, 5'd3, 1'b0, 5'd2, 32'h0, 4'b1111);
    seen = 0;
    repeat (6) begin
      tick();
      if (if1.RVALID !== 1'b0 || if2.RVALID !== 1'b0) seen = 1;
    end
    RST = 1'b1;
    tick();
    checks++;
    if (if1.BUSY !== 1'b1 || if1.DOUT !== 32'h0 || if2.RVALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_midclear busy=%b dout=%h rv2=%b expected 1/0/0", if1.BUSY, if1.DOUT, if2.RVALID);
    end
    RST = 1'b0;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (if1.RVALID !== 1'b0 || if2.RVALID !== 1'b0) seen = 1;
      if (if1.BUSY === 1'b0) break;
    end
    idle();
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL restart_edges edges=%0d expected=17", n);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL busy_rvalid seen=%0d expected=0", seen);
    end
    tick();
    drive(1'b0, 5'd2, 1'b1, 5'd0, 32'h0, 4'h0);
    tick();
    checks++;
    if (if1.DOUT !== 32'hA5A5A5A5 || if1.RVALID !== 1'b1) begin
      errors++;
      $display("FAIL busy_write_ignored dout=%h rvalid=%b expected a5a5a5a5/1", if1.DOUT, if1.RVALID);
    end
    drive(1'b0, 5'd3, 1'b1, 5'd0, 32'h0, 4'h0);
    tick();
    checks++;
    if (if1.DOUT !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL reclear_entry3 dout=%h expected=a5a5a5a5", if1.DOUT);
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_byte_write();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_dp_be.md
# sram_dp_be

Parametrised simple-dual-port synchronous memory: one write port with byte enables, one read port with 1- or 2-cycle registered latency and a read-valid strobe. Successor to the single-port synchronous SRAM model, used for data memory and wide scratch buffers in the core. A built-in clear engine initialises every entry after reset, so contents need no preload file. Optional read-during-write bypass.

## Interface
- BW, 32: data width in bits; must be a multiple of 8
- AW, 10: address width
- ENTRY, 1024: number of entries; ENTRY <= 2^AW
- RLAT, 1: read latency in cycles; legal values 1 or 2, any other value is an elaboration error
- INIT_VAL, 0: BW-bit value written to every entry by the clear engine

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- RCSN  in  1  read request, active low
- RA  in  AW  read address
- WEN  in  1  write enable, active low
- WA  in  AW  write address
- BE  in  BW/8  byte enables for write, bit i covers DI[8i+7:8i], active high
- DI  in  BW  write data
- DOUT  out  BW  read data, registered
- RVALID  out  1  DOUT holds data for a read issued RLAT cycles earlier
- BUSY  out  1  clear engine active; requests ignored

## Operation
- FSM states: RESET, CLEAR, READY.
- RESET: entered at any rising edge with RST=1, from any state, including mid-clear and mid-read. Counter=0, DOUT=0, RVALID=0, read pipeline flushed, BUSY=1.
- RESET -> CLEAR at the first edge with RST=0.
- CLEAR: each edge writes INIT_VAL to entry counter, counter+1. After entry ENTRY-1 is written -> READY. BUSY=1 throughout.
- READY: BUSY=0; accepts requests.
- While BUSY=1, RCSN and WEN are ignored: no write, no RVALID, no pipeline entry.
- Write, in READY: at an edge with WEN=0, for each i with BE[i]=1, ram[WA] byte i <= DI byte i. Other bytes keep their value. BE=0 with WEN=0 is a legal no-op.
- Read, in READY: at an edge with RCSN=0, the request samples ram[RA] and enters the read pipeline.
- Reads and writes are independent. Both ports may be active in the same cycle.
- Same-cycle collision, where RA==WA and both ports are active: behaviour set by the Configuration macro.
- Out-of-range address (>= ENTRY): writes dropped; reads return 0 with normal RVALID timing.
- DOUT holds its last value when no read completes. It is not cleared when RVALID falls.

## Timing
- Reset values: DOUT=0, RVALID=0, BUSY=1.
- BUSY falls exactly ENTRY+1 edges after the edge where RST is first sampled low. This is ENTRY clear edges plus the RESET->CLEAR edge.
- RLAT=1: request at edge n -> DOUT and RVALID update at edge n. Both are visible in cycle n..n+1. RVALID is high for 1 cycle per request.
- RLAT=2: an extra output register. Data is visible one cycle later; RVALID is delayed by the same amount.
- Back-to-back reads: 1 request per cycle, no bubbles, RVALID stays high continuously.
- A write at edge n is visible to a read issued at edge n+1 or later in all configurations.

## Configuration
- SRAM_BYPASS_EN defined: on a same-cycle collision, the read returns the merged word. Bytes with BE=1 come from DI; the other bytes are the old contents.
- SRAM_BYPASS_EN undefined: on a same-cycle collision, the read returns the old contents (read-before-write).

## Test plan
- Reset/clear: ENTRY=16, INIT_VAL=32'hA5A5A5A5, assert RST for 3 cycles then release -> BUSY low exactly 17 edges later. A read of every address returns A5A5A5A5.
- Byte write: write WA=3 DI=32'h11223344 BE=4'b1111, then DI=32'hFFFFFFFF BE=4'b0101 -> a read of RA=3 returns 32'h11FF33FF.
- Latency: RLAT=1 and RLAT=2, reads of addresses 0..7 back-to-back -> RVALID high for 8 consecutive cycles, starting at cycle 1 or 2 after the first request respectively. Data in order.
- Collision: entry 5 = 0, same cycle write WA=RA=5 DI=32'hDEADBEEF BE=4'b0011 -> DOUT=32'h0000BEEF with SRAM_BYPASS_EN, 32'h0 without.
- Reset mid-operation: RST asserted during CLEAR and again with a read in flight -> no RVALID, DOUT=0. The clear restarts from entry 0 with the full ENTRY+1 edge count.
- Requests during BUSY: a write to entry 2 and a read during CLEAR -> no RVALID. After READY, entry 2 reads INIT_VAL.
